reorder_buffer: RTL and testbench

- Circular reorder buffer for the Tomasulo core. It is the producer end of the rename/retire interface that the map table consumes.
- At dispatch it allocates an entry and drives assign_flag with the new ROB tag.
- It captures results broadcast on the CDB and serves operand values to dispatching instructions.
- It retires in order, driving return_flag, dest register and tag back to the map table and the register file.

---
 rtl/reorder_buffer_pkg.sv | 19 +
 rtl/rob_src_read.sv | 51 +++++
 rtl/reorder_buffer.sv | 116 +++++++++++
 tb/tb_reorder_buffer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// rtl/reorder_buffer_pkg.sv - shared sizes, reserved tag and entry layout for the reorder buffer
package reorder_buffer_pkg;

    localparam int ROB_SIZE     = 8;
    localparam int ROB_TAG_LEN  = 4;
    localparam int REG_ADDR_LEN = 5;
    localparam int XLEN         = 32;
    localparam int IDX_W        = $clog2(ROB_SIZE);

    localparam logic [ROB_TAG_LEN-1:0] NULL_ROB_TAG = '1;

    typedef struct packed {
        logic                    valid;
        logic                    ready;
        logic [REG_ADDR_LEN-1:0] dest;
        logic [XLEN-1:0]         value;
    } rob_entry_t;

endpackage

// File: rtl/rob_src_read.sv
// rtl/rob_src_read.sv - operand tag-to-value lookup; ROB_CDB_FWD_EN adds same-cycle CDB forwarding
module rob_src_read
    import reorder_buffer_pkg::*;
(
    input  logic                   enable,
    input  logic [ROB_TAG_LEN-1:0] tag,
    input  logic [ROB_SIZE-1:0]    entry_valid,
    input  logic [ROB_SIZE-1:0]    entry_ready,
    input  logic [XLEN-1:0]        entry_value [ROB_SIZE],
    input  logic                   cdb_valid,
    input  logic [ROB_TAG_LEN-1:0] cdb_rob_tag,
    input  logic [XLEN-1:0]        cdb_value,
    output logic                   ready,
    output logic [XLEN-1:0]        value
);

    logic [IDX_W-1:0] idx;
    logic             hit;

    assign idx = tag[IDX_W-1:0];
    // Tags beyond the buffer depth (including the reserved tag) never hit.
    assign hit = enable && (tag != NULL_ROB_TAG) &&
                 (tag[ROB_TAG_LEN-1:IDX_W] == '0) && entry_valid[idx];

    always_comb begin
        ready = 1'b0;
        value = '0;
        if (hit) begin
`ifdef ROB_CDB_FWD_EN
            if (cdb_valid && (cdb_rob_tag == tag)) begin
                ready = 1'b1;
                value = cdb_value;
            end else if (entry_ready[idx]) begin
                ready = 1'b1;
                value = entry_value[idx];
            end
`else
            if (entry_ready[idx]) begin
                ready = 1'b1;
                value = entry_value[idx];
            end
`endif
        end
    end

`ifndef ROB_CDB_FWD_EN
    logic unused_cdb;
    assign unused_cdb = ^{cdb_valid, cdb_rob_tag, cdb_value};
`endif

endmodule

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - circular in-order-retire reorder buffer; optional ROB_CDB_FWD_EN operand forwarding
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dispatch_valid,
    input  logic [REG_ADDR_LEN-1:0] dispatch_dest,
    output logic                    dispatch_ready,
    output logic                    assign_flag,
    output logic [ROB_TAG_LEN-1:0]  assign_rob_tag,
    input  logic                    cdb_valid,
    input  logic [ROB_TAG_LEN-1:0]  cdb_rob_tag,
    input  logic [XLEN-1:0]         cdb_value,
    input  logic [ROB_TAG_LEN-1:0]  src1_rob_tag,
    output logic                    src1_ready,
    output logic [XLEN-1:0]         src1_value,
    input  logic [ROB_TAG_LEN-1:0]  src2_rob_tag,
    output logic                    src2_ready,
    output logic [XLEN-1:0]         src2_value,
    output logic                    return_flag,
    output logic [REG_ADDR_LEN-1:0] reg_addr_from_rob,
    output logic [ROB_TAG_LEN-1:0]  rob_tag_from_rob,
    output logic [XLEN-1:0]         retire_value,
    input  logic                    flush,
    output logic [ROB_TAG_LEN:0]    rob_count,
    output logic                    rob_empty,
    output logic                    rob_full
);

    rob_entry_t       entries [ROB_SIZE];
    logic [IDX_W:0]   head_ptr, tail_ptr, occupancy;
    logic [IDX_W-1:0] head_idx, tail_idx, cdb_idx;
    logic             cdb_hit;

    logic [ROB_SIZE-1:0] entry_valid, entry_ready;
    logic [XLEN-1:0]     entry_value [ROB_SIZE];

    assign head_idx  = head_ptr[IDX_W-1:0];
    assign tail_idx  = tail_ptr[IDX_W-1:0];
    assign occupancy = tail_ptr - head_ptr;

    assign rob_empty = (head_ptr == tail_ptr);
    assign rob_full  = (head_ptr[IDX_W] != tail_ptr[IDX_W]) && (head_idx == tail_idx);
    assign rob_count = {{(ROB_TAG_LEN - IDX_W){1'b0}}, occupancy};

    // A full buffer stalls dispatch even when the head retires this cycle.
    assign dispatch_ready = reset && !rob_full && !flush;
    assign assign_flag    = dispatch_valid && dispatch_ready;
    assign assign_rob_tag = {{(ROB_TAG_LEN - IDX_W){1'b0}}, tail_idx};

    assign return_flag       = reset && entries[head_idx].valid && entries[head_idx].ready && !flush;
    assign reg_addr_from_rob = entries[head_idx].dest;
    assign rob_tag_from_rob  = {{(ROB_TAG_LEN - IDX_W){1'b0}}, head_idx};
    assign retire_value      = entries[head_idx].value;

    assign cdb_idx = cdb_rob_tag[IDX_W-1:0];
    assign cdb_hit = cdb_valid && (cdb_rob_tag != NULL_ROB_TAG) &&
                     (cdb_rob_tag[ROB_TAG_LEN-1:IDX_W] == '0) && entries[cdb_idx].valid;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
            head_ptr <= '0;
            tail_ptr <= '0;
        end else begin
            if (cdb_hit) begin
                entries[cdb_idx].ready <= 1'b1;
                entries[cdb_idx].value <= cdb_value;
            end
            if (assign_flag) begin
                entries[tail_idx] <= '{valid: 1'b1, ready: 1'b0, dest: dispatch_dest, value: '0};
                tail_ptr          <= tail_ptr + (IDX_W + 1)'(1);
            end
            if (return_flag) begin
                entries[head_idx] <= '0;
                head_ptr          <= head_ptr + (IDX_W + 1)'(1);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            entry_valid[i] = entries[i].valid;
            entry_ready[i] = entries[i].ready;
            entry_value[i] = entries[i].value;
        end
    end

    rob_src_read u_src1 (
        .enable      (reset),
        .tag         (src1_rob_tag),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_value (entry_value),
        .cdb_valid   (cdb_valid),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_value   (cdb_value),
        .ready       (src1_ready),
        .value       (src1_value)
    );

    rob_src_read u_src2 (
        .enable      (reset),
        .tag         (src2_rob_tag),
        .entry_valid (entry_valid),
        .entry_ready (entry_ready),
        .entry_value (entry_value),
        .cdb_valid   (cdb_valid),
        .cdb_rob_tag (cdb_rob_tag),
        .cdb_value   (cdb_value),
        .ready       (src2_ready),
        .value       (src2_value)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// tb/tb_reorder_buffer.sv - self-checking bench for reorder_buffer against a count-based reference model
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        dispatch_valid;
    logic [4:0]  dispatch_dest;
    logic        dispatch_ready;
    logic        assign_flag;
    logic [3:0]  assign_rob_tag;
    logic        cdb_valid;
    logic [3:0]  cdb_rob_tag;
    logic [31:0] cdb_value;
    logic [3:0]  src1_rob_tag;
    logic        src1_ready;
    logic [31:0] src1_value;
    logic [3:0]  src2_rob_tag;
    logic        src2_ready;
    logic [31:0] src2_value;
    logic        return_flag;
    logic [4:0]  reg_addr_from_rob;
    logic [3:0]  rob_tag_from_rob;
    logic [31:0] retire_value;
    logic        flush;
    logic [4:0]  rob_count;
    logic        rob_empty;
    logic        rob_full;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk               (clk),
        .reset             (reset),
        .dispatch_valid    (dispatch_valid),
        .dispatch_dest     (dispatch_dest),
        .dispatch_ready    (dispatch_ready),
        .assign_flag       (assign_flag),
        .assign_rob_tag    (assign_rob_tag),
        .cdb_valid         (cdb_valid),
        .cdb_rob_tag       (cdb_rob_tag),
        .cdb_value         (cdb_value),
        .src1_rob_tag      (src1_rob_tag),
        .src1_ready        (src1_ready),
        .src1_value        (src1_value),
        .src2_rob_tag      (src2_rob_tag),
        .src2_ready        (src2_ready),
        .src2_value        (src2_value),
        .return_flag       (return_flag),
        .reg_addr_from_rob (reg_addr_from_rob),
        .rob_tag_from_rob  (rob_tag_from_rob),
        .retire_value      (retire_value),
        .flush             (flush),
        .rob_count         (rob_count),
        .rob_empty         (rob_empty),
        .rob_full          (rob_full)
    );

    // Reference model: occupancy count plus head index over a plain array.
    bit          m_v [8];
    bit          m_r [8];
    logic [4:0]  m_d [8];
    logic [31:0] m_x [8];
    int          m_head = 0;
    int          m_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_src(input logic [3:0] t, output bit rdy, output logic [31:0] val);
        rdy = 0;
        val = '0;
        if (reset && t < 8 && m_v[t]) begin
`ifdef ROB_CDB_FWD_EN
            if (cdb_valid && cdb_rob_tag == t) begin
                rdy = 1;
                val = cdb_value;
            end else if (m_r[t]) begin
                rdy = 1;
                val = m_x[t];
            end
`else
            if (m_r[t]) begin
                rdy = 1;
                val = m_x[t];
            end
`endif
        end
    endtask

    task automatic model_check();
        bit full, dr, af, rf, r1, r2;
        logic [31:0] v1, v2;
        full = (m_cnt == 8);
        dr   = reset && !full && !flush;
        af   = dispatch_valid && dr;
        rf   = reset && m_v[m_head] && m_r[m_head] && !flush;
        chk("dispatch_ready", dispatch_ready, dr);
        chk("assign_flag", assign_flag, af);
        chk("assign_rob_tag", assign_rob_tag, (m_head + m_cnt) % 8);
        chk("return_flag", return_flag, rf);
        chk("rob_count", rob_count, m_cnt);
        chk("rob_empty", rob_empty, m_cnt == 0);
        chk("rob_full", rob_full, full);
        if (rf) begin
            chk("reg_addr_from_rob", reg_addr_from_rob, m_d[m_head]);
            chk("rob_tag_from_rob", rob_tag_from_rob, m_head);
            chk("retire_value", retire_value, m_x[m_head]);
        end
        exp_src(src1_rob_tag, r1, v1);
        exp_src(src2_rob_tag, r2, v2);
        chk("src1_ready", src1_ready, r1);
        chk("src1_value", src1_value, v1);
        chk("src2_ready", src2_ready, r2);
        chk("src2_value", src2_value, v2);
    endtask

    task automatic model_update();
        bit af, rf;
        int tail;
        if (!reset || flush) begin
            for (int i = 0; i < 8; i++) begin
                m_v[i] = 0; m_r[i] = 0; m_d[i] = '0; m_x[i] = '0;
            end
            m_head = 0;
            m_cnt  = 0;
        end else begin
            af   = dispatch_valid && (m_cnt < 8);
            rf   = m_v[m_head] && m_r[m_head];
            tail = (m_head + m_cnt) % 8;
            if (cdb_valid && cdb_rob_tag < 8 && m_v[cdb_rob_tag]) begin
                m_r[cdb_rob_tag] = 1;
                m_x[cdb_rob_tag] = cdb_value;
            end
            if (af) begin
                m_v[tail] = 1; m_r[tail] = 0; m_d[tail] = dispatch_dest; m_x[tail] = '0;
            end
            if (rf) begin
                m_v[m_head] = 0; m_r[m_head] = 0; m_d[m_head] = '0; m_x[m_head] = '0;
                m_head = (m_head + 1) % 8;
            end
            m_cnt = m_cnt + int'(af) - int'(rf);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid = 0; dispatch_dest = '0;
        cdb_valid = 0; cdb_rob_tag = '0; cdb_value = '0;
        flush = 0;
    endtask

    typedef struct {
        logic        dv;
        logic [4:0]  dest;
        logic        cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic        ea;
        logic [3:0]  et;
        logic        er;
        logic [4:0]  ec;
        logic [4:0]  erd;
        logic [31:0] erv;
    } vec_t;

    vec_t vecs [17];

    task automatic setv(input int i, input logic dv, input logic [4:0] dest, input logic cv,
                        input logic [3:0] ct, input logic [31:0] cval, input logic ea,
                        input logic [3:0] et, input logic er, input logic [4:0] ec,
                        input logic [4:0] erd, input logic [31:0] erv);
        vecs[i] = '{dv, dest, cv, ct, cval, ea, et, er, ec, erd, erv};
    endtask

    initial begin
        reset = 0;
        idle_inputs();
        src1_rob_tag = 4'hF;
        src2_rob_tag = 4'hF;

        // Directed fill / out-of-order completion / in-order retire sequence.
        for (int i = 0; i < 8; i++) setv(i, 1, 5'(i + 1), 0, 0, 0, 1, 4'(i), 0, 5'(i), 0, 0);
        setv(8,  1, 9, 0, 0, 0,       0, 0, 0, 8, 0, 0);
        setv(9,  0, 0, 1, 2, 32'hAA,  0, 0, 0, 8, 0, 0);
        setv(10, 0, 0, 1, 0, 32'h11,  0, 0, 0, 8, 0, 0);
        setv(11, 0, 0, 0, 0, 0,       0, 0, 1, 8, 1, 32'h11);
        setv(12, 0, 0, 0, 0, 0,       0, 0, 0, 7, 0, 0);
        setv(13, 0, 0, 1, 1, 32'h22,  0, 0, 0, 7, 0, 0);
        setv(14, 0, 0, 0, 0, 0,       0, 0, 1, 7, 2, 32'h22);
        setv(15, 0, 0, 0, 0, 0,       0, 0, 1, 6, 3, 32'hAA);
        setv(16, 0, 0, 0, 0, 0,       0, 0, 0, 5, 0, 0);

        // Reset held low for two edges; outputs must be forced low meanwhile.
        advance();
        dispatch_valid = 1;
        src1_rob_tag = 0;
        settle();
        chk("rst_dispatch_ready", dispatch_ready, 0);
        chk("rst_assign_flag", assign_flag, 0);
        advance();
        reset = 1;
        idle_inputs();
        settle();
        chk("post_rst_empty", rob_empty, 1);
        chk("post_rst_dispatch_ready", dispatch_ready, 1);
        chk("post_rst_tag", assign_rob_tag, 0);
        chk("post_rst_return_flag", return_flag, 0);
        chk("post_rst_full", rob_full, 0);
        chk("post_rst_retire_value", retire_value, 0);
        chk("post_rst_src1_value", src1_value, 0);
        advance();

        for (int i = 0; i < 17; i++) begin
            dispatch_valid = vecs[i].dv;
            dispatch_dest  = vecs[i].dest;
            cdb_valid      = vecs[i].cv;
            cdb_rob_tag    = vecs[i].ct;
            cdb_value      = vecs[i].cval;
            settle();
            chk($sformatf("vec%0d_assign_flag", i), assign_flag, vecs[i].ea);
            chk($sformatf("vec%0d_assign_tag", i), assign_rob_tag, vecs[i].et);
            chk($sformatf("vec%0d_return_flag", i), return_flag, vecs[i].er);
            chk($sformatf("vec%0d_count", i), rob_count, vecs[i].ec);
            if (vecs[i].er) begin
                chk($sformatf("vec%0d_ret_dest", i), reg_addr_from_rob, vecs[i].erd);
                chk($sformatf("vec%0d_ret_value", i), retire_value, vecs[i].erv);
            end
            advance();
        end
        idle_inputs();

        // Same-cycle operand read of a broadcast tag; reserved tag never ready.
        src1_rob_tag = 3;
        src2_rob_tag = 4'hF;
        cdb_valid = 1; cdb_rob_tag = 3; cdb_value = 32'h55;
        settle();
`ifdef ROB_CDB_FWD_EN
        chk("fwd_src1_ready", src1_ready, 1);
        chk("fwd_src1_value", src1_value, 32'h55);
`else
        chk("fwd_src1_ready", src1_ready, 0);
        chk("fwd_src1_value", src1_value, 0);
`endif
        chk("null_src2_ready", src2_ready, 0);
        advance();
        idle_inputs();
        settle();
        chk("late_src1_ready", src1_ready, 1);
        chk("late_src1_value", src1_value, 32'h55);
        advance();

        // Build 5 entries with a ready head, then flush with dispatch requested.
        dispatch_valid = 1; dispatch_dest = 10;
        settle();
        advance();
        idle_inputs();
        cdb_valid = 1; cdb_rob_tag = 4; cdb_value = 32'h44;
        settle();
        advance();
        idle_inputs();
        flush = 1; dispatch_valid = 1;
        settle();
        chk("flush_count_before", rob_count, 5);
        chk("flush_assign_flag", assign_flag, 0);
        chk("flush_return_flag", return_flag, 0);
        advance();
        idle_inputs();
        settle();
        chk("post_flush_empty", rob_empty, 1);
        chk("post_flush_tag", assign_rob_tag, 0);
        advance();

        // Full buffer with dispatch held: retire first, dispatch at wrapped tag 0 next cycle.
        for (int i = 0; i < 8; i++) begin
            dispatch_valid = 1; dispatch_dest = 5'(20 + i);
            settle();
            advance();
        end
        cdb_valid = 1; cdb_rob_tag = 0; cdb_value = 32'h77;
        settle();
        chk("full_hold_assign", assign_flag, 0);
        advance();
        cdb_valid = 0;
        settle();
        chk("full_retire_ret", return_flag, 1);
        chk("full_retire_assign", assign_flag, 0);
        chk("full_retire_value", retire_value, 32'h77);
        advance();
        settle();
        chk("wrap_assign", assign_flag, 1);
        chk("wrap_tag", assign_rob_tag, 0);
        chk("wrap_count", rob_count, 7);
        advance();
        dispatch_valid = 0;
        settle();
        chk("refill_full", rob_full, 1);
        advance();

        // Randomized traffic against the model, including mid-run flush and reset.
        for (int c = 0; c < 400; c++) begin
            int span;
            reset          = ($urandom_range(0, 99) != 0);
            flush          = ($urandom_range(0, 49) == 0);
            dispatch_valid = ($urandom_range(0, 9) < 6);
            dispatch_dest  = 5'($urandom_range(0, 31));
            cdb_valid      = ($urandom_range(0, 9) < 6);
            span           = (m_cnt > 0) ? m_cnt - 1 : 0;
            if ($urandom_range(0, 3) != 0)
                cdb_rob_tag = 4'((m_head + $urandom_range(0, span)) % 8);
            else
                cdb_rob_tag = 4'($urandom_range(0, 15));
            cdb_value    = $urandom;
            src1_rob_tag = 4'($urandom_range(0, 15));
            src2_rob_tag = ($urandom_range(0, 1) != 0) ? cdb_rob_tag : 4'($urandom_range(0, 15));
            settle();
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
